counter_bcd_range: RTL and testbench
====================================

Name: counter_bcd_range

Overview:
- Parametrised N-digit BCD up/down counter with programmable inclusive range [MIN_BCD, MAX_BCD] and wrap-around in both directions.
- Next-generation replacement for the fixed 4-digit year counter. The same block also serves other calendar fields: year, century-style fields, and any field with non-zero-based limits.
- Runs from the lower-stage tick in run mode and from edge-detected up/down buttons in set mode.
- Adds parallel load with validation and a registered carry pulse for cascading.

Parameters:
- DIGITS, 4, number of BCD digits; value width W = 4*DIGITS.
- MIN_BCD, 16'h2005, lowest legal value (packed BCD, W bits).
- MAX_BCD, 16'h3000, highest legal value (packed BCD, W bits).
- RST_BCD, 16'h2005, value after reset.
- REPEAT_DELAY, 50_000_000, cycles from first step to first auto-repeat step (used only with the macro).
- REPEAT_PERIOD, 10_000_000, cycles between later auto-repeat steps (used only with the macro).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- mode_run  in  1  1 = run (count on tick), 0 = set (count on buttons).
- tick  in  1  single-cycle advance strobe from the lower stage.
- up  in  1  synchronised up button level.
- down  in  1  synchronised down button level.
- load  in  1  single-cycle parallel-load strobe.
- load_val  in  W  packed BCD value to load.
- value  out  W  packed BCD count; digit 0 occupies bits [3:0].
- carry  out  1  one-cycle pulse on a run-mode wrap from MAX to MIN.
- load_err  out  1  one-cycle pulse when a load is rejected.

Behaviour:
- Reset (async, rst=1): value=RST_BCD, carry=0, load_err=0, up_q=0, down_q=0, repeat counter=0. Reset mid-operation aborts any pending repeat.
- All outputs are registered. Any step is visible 1 cycle after its cause.
- Priority each cycle: load > run-mode tick > set-mode button step.
- Load:
  - Accepted only if every digit of load_val is <=9 and MIN_BCD <= load_val <= MAX_BCD (BCD compare equals binary compare). Accepted load sets value=load_val.
  - Otherwise value is held and load_err pulses.
  - A load in the same cycle as a tick or button step wins; that step is dropped.
- Run mode (mode_run=1):
  - tick=1 with value==MAX_BCD: value=MIN_BCD, carry=1 for that cycle.
  - tick=1 otherwise: value=value+1 in BCD (digit 9 rolls to 0 and carries to the next digit).
  - up and down are ignored.
- Set mode (mode_run=0):
  - Step only on a rising edge: up_rise = up & ~up_q, likewise down_rise.
  - up_rise: +1, with MAX_BCD wrapping to MIN_BCD.
  - down_rise: -1 in BCD with a full borrow chain (digit 0 goes to 9 and borrows from the next digit, through every digit), with MIN_BCD wrapping to MAX_BCD.
  - up_rise and down_rise in the same cycle: no step.
  - tick is ignored. carry never pulses in set mode.
- up_q and down_q register every cycle in both modes. A mode change therefore never produces a spurious step. A button held at reset release gives one step.
- Values outside [MIN, MAX] are unreachable except through the reset parameter. Elaboration-time checks are fatal if MIN>MAX, RST is out of range, or any parameter digit is >9.

Optional Feature:
- Macro: COUNTER_BCD_AUTO_REPEAT_EN.
- Defined:
  - While in set mode with exactly one of up/down held, a cycle counter runs from the edge step (count 0).
  - Extra steps occur at counts REPEAT_DELAY, REPEAT_DELAY+REPEAT_PERIOD, and so on, in the held direction, with wrap.
  - The counter clears on release, on both buttons held, on mode_run=1, or on load.
  - The counter saturates and never wraps into a false step.
- Undefined: the repeat logic is absent; holding a button gives exactly one step.

Decomposition:
- Package counter_pkg holds:
  - typedef bcd_digit_t (4 bits).
  - Year defaults YEAR_MIN_BCD=16'h2005, YEAR_MAX_BCD=16'h3000.
  - Function bcd_valid(value, digits).
- Sub-module bcd_step: purely combinational W-bit BCD ±1. Inputs: value, dir. Outputs: next, at_limit (compared against the range parameters), applying the wrap.
- counter_bcd_range holds the edge detect, priority, registers and repeat timer.

Test Plan:
- Reset with defaults: value=16'h2005, carry=0. Run mode, ticks from 16'h2999: value becomes 16'h3000; next tick gives 16'h2005 and carry=1 for exactly 1 cycle.
- Set mode, down held 5 cycles from 16'h2005: a single step to 16'h3000. Then down edges give 16'h2999, then 16'h2998; check the full borrow chain from 16'h2100 to 16'h2099.
- Set mode, up and down rising in the same cycle: value unchanged. Up held while toggling mode_run 0→1→0: no step.
- Load 16'h2500: value=16'h2500. Load 16'h20A5 or 16'h1999: value held, load_err=1 for 1 cycle. Load plus tick in the same cycle: value=load_val.
- With COUNTER_BCD_AUTO_REPEAT_EN, REPEAT_DELAY=4, REPEAT_PERIOD=2: hold up 9 cycles from 16'h2005. Steps at counts 0, 4, 6, 8 give 16'h2009; release clears the counter.
- Assert rst mid-repeat and mid-carry: value=RST_BCD immediately (async), carry=0, no repeat step after release.

Source files
------------

// File: rtl/counter_bcd_range_pkg.sv
// Shared types, year-field defaults and BCD helpers for the range counter family.
package counter_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam logic [15:0] YEAR_MIN_BCD = 16'h2005;
  localparam logic [15:0] YEAR_MAX_BCD = 16'h3000;

  typedef enum logic [1:0] {
    REP_IDLE,
    REP_DELAY,
    REP_PERIOD
  } rep_state_t;

  // True when every one of the low 'digits' nibbles is a legal decimal digit.
  function automatic logic bcd_valid(input logic [63:0] value, input int unsigned digits);
    logic ok;
    ok = 1'b1;
    for (int unsigned i = 0; i < 16; i++) begin
      if (i < digits && value[4*i +: 4] > 4'd9) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/counter_bcd_range_if.sv
// Control/data bundle between a controller (master) and counter_bcd_range (slave).
interface counter_bcd_range_if #(
  parameter int unsigned W = 16
) ();

  logic         mode_run;
  logic         tick;
  logic         up;
  logic         down;
  logic         load;
  logic [W-1:0] load_val;
  logic [W-1:0] value;
  logic         carry;
  logic         load_err;

  modport master (
    output mode_run, tick, up, down, load, load_val,
    input  value, carry, load_err
  );

  modport slave (
    input  mode_run, tick, up, down, load, load_val,
    output value, carry, load_err
  );

endinterface

// File: rtl/counter_bcd_range_bcd_step.sv
// Combinational packed-BCD +/-1 with wrap at the range limits (dir=1 counts up).
module bcd_step
  import counter_pkg::*;
#(
  parameter int unsigned         DIGITS  = 4,
  parameter logic [4*DIGITS-1:0] MIN_BCD = YEAR_MIN_BCD,
  parameter logic [4*DIGITS-1:0] MAX_BCD = YEAR_MAX_BCD
) (
  input  logic [4*DIGITS-1:0] value,
  input  logic                dir,
  output logic [4*DIGITS-1:0] next,
  output logic                at_limit
);

  logic [4*DIGITS-1:0] ripple;
  logic                chain;
  bcd_digit_t          d;

  // Digit-serial carry/borrow; chain stays set only while digits roll over.
  always_comb begin
    ripple = value;
    chain  = 1'b1;
    d      = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      d = value[4*i +: 4];
      if (chain) begin
        if (dir) begin
          if (d >= 4'd9) begin
            ripple[4*i +: 4] = '0;
          end else begin
            ripple[4*i +: 4] = d + 4'd1;
            chain            = 1'b0;
          end
        end else begin
          if (d == '0) begin
            ripple[4*i +: 4] = 4'd9;
          end else begin
            ripple[4*i +: 4] = d - 4'd1;
            chain            = 1'b0;
          end
        end
      end
    end
  end

  always_comb begin
    at_limit = dir ? (value == MAX_BCD) : (value == MIN_BCD);
    next     = ripple;
    if (at_limit) next = dir ? MIN_BCD : MAX_BCD;
  end

endmodule

// File: rtl/counter_bcd_range.sv
// N-digit BCD range counter with load validation and cascade carry.
// Optional held-button auto-repeat: define COUNTER_BCD_AUTO_REPEAT_EN.
module counter_bcd_range
  import counter_pkg::*;
#(
  parameter int unsigned         DIGITS        = 4,
  parameter logic [4*DIGITS-1:0] MIN_BCD       = YEAR_MIN_BCD,
  parameter logic [4*DIGITS-1:0] MAX_BCD       = YEAR_MAX_BCD,
  parameter logic [4*DIGITS-1:0] RST_BCD       = YEAR_MIN_BCD,
  parameter int unsigned         REPEAT_DELAY  = 50_000_000,
  parameter int unsigned         REPEAT_PERIOD = 10_000_000
) (
  input logic                 clk,
  input logic                 rst,
  counter_bcd_range_if.slave  bus
);

  localparam int unsigned W = 4 * DIGITS;

  if (DIGITS < 1 || DIGITS > 16) begin : g_bad_digits
    $fatal(1, "counter_bcd_range: DIGITS must be 1..16");
  end
  if (!bcd_valid(64'(MIN_BCD), DIGITS) || !bcd_valid(64'(MAX_BCD), DIGITS) ||
      !bcd_valid(64'(RST_BCD), DIGITS)) begin : g_bad_bcd
    $fatal(1, "counter_bcd_range: parameter digit above 9");
  end
  if (MIN_BCD > MAX_BCD) begin : g_bad_range
    $fatal(1, "counter_bcd_range: MIN_BCD > MAX_BCD");
  end
  if (RST_BCD < MIN_BCD || RST_BCD > MAX_BCD) begin : g_bad_rst
    $fatal(1, "counter_bcd_range: RST_BCD outside range");
  end
  if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_repeat
    $fatal(1, "counter_bcd_range: repeat timings must be non-zero");
  end

  logic [W-1:0] value_q, value_d;
  logic         carry_q, carry_d;
  logic         err_q, err_d;
  logic         up_q, down_q;

  logic         up_rise, down_rise;
  logic         set_up, set_dn;
  logic         step_dir, step_at_limit;
  logic [W-1:0] step_next;
  logic         load_ok;
  logic         rep_step;

  assign up_rise   = bus.up & ~up_q;
  assign down_rise = bus.down & ~down_q;

  assign set_up   = ~bus.mode_run & ((up_rise & ~down_rise) | (rep_step & bus.up));
  assign set_dn   = ~bus.mode_run & ((down_rise & ~up_rise) | (rep_step & bus.down));
  assign step_dir = bus.mode_run | set_up;

  assign load_ok = bcd_valid(64'(bus.load_val), DIGITS) &&
                   (bus.load_val >= MIN_BCD) && (bus.load_val <= MAX_BCD);

  bcd_step #(
    .DIGITS  (DIGITS),
    .MIN_BCD (MIN_BCD),
    .MAX_BCD (MAX_BCD)
  ) u_step (
    .value    (value_q),
    .dir      (step_dir),
    .next     (step_next),
    .at_limit (step_at_limit)
  );

`ifdef COUNTER_BCD_AUTO_REPEAT_EN
  rep_state_t  rep_state_q, rep_state_d;
  logic [31:0] rep_cnt_q, rep_cnt_d;
  logic        rep_clear, edge_step;

  assign rep_clear = ~(bus.up ^ bus.down) | bus.mode_run | bus.load;
  assign edge_step = up_rise ^ down_rise;

  // rep_cnt_q counts cycles since the last step, so phases compare against
  // the delay first and the period afterwards; it saturates instead of wrapping.
  always_comb begin
    rep_state_d = rep_state_q;
    rep_cnt_d   = rep_cnt_q;
    rep_step    = 1'b0;
    if (rep_clear) begin
      rep_state_d = REP_IDLE;
      rep_cnt_d   = '0;
    end else if (edge_step) begin
      rep_state_d = REP_DELAY;
      rep_cnt_d   = 32'd1;
    end else begin
      case (rep_state_q)
        REP_DELAY, REP_PERIOD: begin
          if (rep_cnt_q == ((rep_state_q == REP_DELAY) ? REPEAT_DELAY : REPEAT_PERIOD)) begin
            rep_step    = 1'b1;
            rep_state_d = REP_PERIOD;
            rep_cnt_d   = 32'd1;
          end else if (rep_cnt_q != '1) begin
            rep_cnt_d = rep_cnt_q + 32'd1;
          end
        end
        default: rep_state_d = REP_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rep_state_q <= REP_IDLE;
      rep_cnt_q   <= '0;
    end else begin
      rep_state_q <= rep_state_d;
      rep_cnt_q   <= rep_cnt_d;
    end
  end
`else
  assign rep_step = 1'b0;
`endif

  always_comb begin
    value_d = value_q;
    carry_d = 1'b0;
    err_d   = 1'b0;
    if (bus.load) begin
      if (load_ok) value_d = bus.load_val;
      else         err_d   = 1'b1;
    end else if (bus.mode_run) begin
      if (bus.tick) begin
        value_d = step_next;
        carry_d = step_at_limit;
      end
    end else if (set_up | set_dn) begin
      value_d = step_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value_q <= RST_BCD;
      carry_q <= 1'b0;
      err_q   <= 1'b0;
      up_q    <= 1'b0;
      down_q  <= 1'b0;
    end else begin
      value_q <= value_d;
      carry_q <= carry_d;
      err_q   <= err_d;
      up_q    <= bus.up;
      down_q  <= bus.down;
    end
  end

  assign bus.value    = value_q;
  assign bus.carry    = carry_q;
  assign bus.load_err = err_q;

endmodule

// File: tb/tb_counter_bcd_range.sv
// Directed-vector bench for counter_bcd_range (year defaults, short repeat timings).
module tb_counter_bcd_range;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;

  counter_bcd_range_if #(.W(16)) bus ();

  counter_bcd_range #(
    .DIGITS        (4),
    .MIN_BCD       (16'h2005),
    .MAX_BCD       (16'h3000),
    .RST_BCD       (16'h2005),
    .REPEAT_DELAY  (4),
    .REPEAT_PERIOD (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        mode_run;
    logic        tick;
    logic        up;
    logic        down;
    logic        load;
    logic [15:0] load_val;
    logic [15:0] exp_value;
    logic        exp_carry;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic m, t, u, d, l, input logic [15:0] lv,
                     input logic [15:0] ev, input logic ec, ee);
    vec_t v;
    v.mode_run = m; v.tick = t; v.up = u; v.down = d; v.load = l; v.load_val = lv;
    v.exp_value = ev; v.exp_carry = ec; v.exp_err = ee;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic m, t, u, d, l, input logic [15:0] lv);
    bus.mode_run = m; bus.tick = t; bus.up = u; bus.down = d;
    bus.load = l; bus.load_val = lv;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  logic [15:0] hold_exp [0:8];
  logic [15:0] rehold_exp [0:4];

  initial begin
    // mode_run tick up down load load_val -> value carry load_err
    add(0,0,0,0,1,16'h2999, 16'h2999,0,0);
    add(1,1,0,0,0,16'h0000, 16'h3000,0,0);
    add(1,1,0,0,0,16'h0000, 16'h2005,1,0);
    add(1,0,0,0,0,16'h0000, 16'h2005,0,0);
    add(1,1,0,0,0,16'h0000, 16'h2006,0,0);
    add(1,0,1,0,0,16'h0000, 16'h2006,0,0);
    add(0,0,1,0,0,16'h0000, 16'h2006,0,0);
    add(1,0,1,0,0,16'h0000, 16'h2006,0,0);
    add(0,0,1,0,0,16'h0000, 16'h2006,0,0);
    add(0,0,0,0,0,16'h0000, 16'h2006,0,0);
    add(0,0,1,1,0,16'h0000, 16'h2006,0,0);
    add(0,0,0,0,0,16'h0000, 16'h2006,0,0);
    add(0,0,0,0,1,16'h2005, 16'h2005,0,0);
    add(0,0,0,1,0,16'h0000, 16'h3000,0,0);
    add(0,0,0,1,0,16'h0000, 16'h3000,0,0);
    add(0,0,0,1,0,16'h0000, 16'h3000,0,0);
    add(0,0,0,1,0,16'h0000, 16'h3000,0,0);
    add(0,0,0,0,0,16'h0000, 16'h3000,0,0);
    add(0,0,0,1,0,16'h0000, 16'h2999,0,0);
    add(0,0,0,0,0,16'h0000, 16'h2999,0,0);
    add(0,0,0,1,0,16'h0000, 16'h2998,0,0);
    add(0,0,0,0,1,16'h2100, 16'h2100,0,0);
    add(0,0,0,1,0,16'h0000, 16'h2099,0,0);
    add(0,0,0,0,1,16'h2500, 16'h2500,0,0);
    add(0,0,0,0,1,16'h20A5, 16'h2500,0,1);
    add(0,0,0,0,0,16'h0000, 16'h2500,0,0);
    add(0,0,0,0,1,16'h1999, 16'h2500,0,1);
    add(0,0,0,0,1,16'h3001, 16'h2500,0,1);
    add(0,0,0,0,1,16'h3000, 16'h3000,0,0);
    add(0,0,1,0,0,16'h0000, 16'h2005,0,0);
    add(0,0,0,0,0,16'h0000, 16'h2005,0,0);
    add(0,1,0,0,0,16'h0000, 16'h2005,0,0);
    add(1,1,0,0,1,16'h2222, 16'h2222,0,0);
    add(0,0,1,0,1,16'h2300, 16'h2300,0,0);
    add(0,0,0,0,0,16'h0000, 16'h2300,0,0);
    add(0,0,1,0,0,16'h0000, 16'h2301,0,0);
    add(0,0,0,0,1,16'h2009, 16'h2009,0,0);
    add(1,1,0,0,0,16'h0000, 16'h2010,0,0);
    add(1,0,0,0,1,16'h2099, 16'h2099,0,0);
    add(1,1,0,0,0,16'h0000, 16'h2100,0,0);
    add(1,0,0,0,1,16'h2999, 16'h2999,0,0);
    add(1,1,0,0,1,16'h20A5, 16'h2999,0,1);
    add(0,0,0,1,0,16'h0000, 16'h2998,0,0);
    add(0,0,0,0,0,16'h0000, 16'h2998,0,0);

`ifdef COUNTER_BCD_AUTO_REPEAT_EN
    hold_exp   = '{16'h2006, 16'h2006, 16'h2006, 16'h2006, 16'h2007,
                   16'h2007, 16'h2008, 16'h2008, 16'h2009};
    rehold_exp = '{16'h2010, 16'h2010, 16'h2010, 16'h2010, 16'h2011};
`else
    hold_exp   = '{16'h2006, 16'h2006, 16'h2006, 16'h2006, 16'h2006,
                   16'h2006, 16'h2006, 16'h2006, 16'h2006};
    rehold_exp = '{16'h2007, 16'h2007, 16'h2007, 16'h2007, 16'h2007};
`endif

    drive(0,0,0,0,0,16'h0000);
    rst = 1'b1;
    #12;
    chk("reset value", 32'(bus.value), 32'h2005);
    chk("reset carry", 32'(bus.carry), 32'h0);
    chk("reset load_err", 32'(bus.load_err), 32'h0);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].mode_run, vecs[i].tick, vecs[i].up, vecs[i].down,
            vecs[i].load, vecs[i].load_val);
      cyc();
      chk($sformatf("vec%0d value", i), 32'(bus.value), 32'(vecs[i].exp_value));
      chk($sformatf("vec%0d carry", i), 32'(bus.carry), 32'(vecs[i].exp_carry));
      chk($sformatf("vec%0d load_err", i), 32'(bus.load_err), 32'(vecs[i].exp_err));
    end

    // Long hold of up, release, then a fresh hold that must restart the timer.
    drive(0,0,0,0,1,16'h2005);
    cyc();
    chk("hold preload", 32'(bus.value), 32'h2005);
    for (int i = 0; i < 9; i++) begin
      drive(0,0,1,0,0,16'h0000);
      cyc();
      chk($sformatf("hold%0d value", i), 32'(bus.value), 32'(hold_exp[i]));
    end
    drive(0,0,0,0,0,16'h0000);
    cyc();
    chk("hold release", 32'(bus.value), 32'(hold_exp[8]));
    for (int i = 0; i < 5; i++) begin
      drive(0,0,1,0,0,16'h0000);
      cyc();
      chk($sformatf("rehold%0d value", i), 32'(bus.value), 32'(rehold_exp[i]));
    end
    drive(0,0,0,0,0,16'h0000);
    cyc();

    // Reset asserted mid-repeat: immediate async effect, no later repeat step.
    drive(0,0,0,0,1,16'h2500);
    cyc();
    drive(0,0,1,0,0,16'h0000);
    cyc();
    cyc();
    chk("pre-reset value", 32'(bus.value), 32'h2501);
    #2;
    rst = 1'b1;
    #1;
    chk("async reset value", 32'(bus.value), 32'h2005);
    chk("async reset carry", 32'(bus.carry), 32'h0);
    drive(0,0,0,0,0,16'h0000);
    cyc();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cyc();
      chk($sformatf("post-reset%0d value", i), 32'(bus.value), 32'h2005);
    end

    // Button already held when reset releases: exactly one step.
    rst = 1'b1;
    drive(0,0,1,0,0,16'h0000);
    cyc();
    rst = 1'b0;
    cyc();
    chk("held at release", 32'(bus.value), 32'h2006);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk($sformatf("held after%0d", i), 32'(bus.value), 32'h2006);
    end
    drive(0,0,0,0,0,16'h0000);
    cyc();

    // Reset while the carry pulse is high.
    drive(1,0,0,0,1,16'h3000);
    cyc();
    drive(1,1,0,0,0,16'h0000);
    cyc();
    chk("wrap carry", 32'(bus.carry), 32'h1);
    chk("wrap value", 32'(bus.value), 32'h2005);
    #2;
    rst = 1'b1;
    #1;
    chk("reset kills carry", 32'(bus.carry), 32'h0);
    drive(0,0,0,0,0,16'h0000);
    cyc();
    rst = 1'b0;
    cyc();
    chk("after carry reset", 32'(bus.value), 32'h2005);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
